// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and load-use detection.
// The results are registered into the EX/MEM pipeline register for the memory stage.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regwrite_i,
  input  logic        alusrc_i,
  input  logic        branch_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic        memtoreg_i,
  input  logic [31:0] imme_i,
  input  logic [31:0] rdata1_i,
  input  logic [31:0] rdata2_i,
  input  logic [13:0] addr_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [3:0]  alucontrol_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        wb_regwrite_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] exmem_alu_o,
  output logic [31:0] exmem_wdata_o,
  output logic [4:0]  exmem_rd_o,
  output logic        exmem_regwrite_o,
  output logic        exmem_memread_o,
  output logic        exmem_memwrite_o,
  output logic        exmem_memtoreg_o,
  output logic [13:0] branch_target_o,
  output logic        flush_o,
  output logic        stall_o
);

  logic [31:0] r_alu;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_memwrite;
  logic        r_memtoreg;

  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_opb;
  logic [31:0] w_alu;

  // A load sitting in EX/MEM has no data yet, so it is skipped; the load-use stall covers it.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  rs,
    input logic [31:0] rdata,
    input logic        em_we,
    input logic        em_load,
    input logic [4:0]  em_rd,
    input logic [31:0] em_data,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (em_we && !em_load && (em_rd != 5'd0) && (em_rd == rs))
      return em_data;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      return wb_data;
    else
      return rdata;
  endfunction

  always_comb begin
    w_fwd_a = fwd_sel(rs1_i, rdata1_i, r_regwrite, r_memread, r_rd, r_alu,
                      wb_regwrite_i, wb_rd_i, wb_data_i);
    w_fwd_b = fwd_sel(rs2_i, rdata2_i, r_regwrite, r_memread, r_rd, r_alu,
                      wb_regwrite_i, wb_rd_i, wb_data_i);
    w_opb   = alusrc_i ? imme_i : w_fwd_b;
  end

  always_comb begin
    w_alu = 32'd0;
    case (alucontrol_i)
      4'b0000: w_alu = w_fwd_a & w_opb;
      4'b0001: w_alu = w_fwd_a | w_opb;
      4'b0010: w_alu = w_fwd_a + w_opb;
      4'b0011: w_alu = w_fwd_a ^ w_opb;
      4'b0100: w_alu = w_fwd_a << w_opb[4:0];
      4'b0101: w_alu = w_fwd_a >> w_opb[4:0];
      4'b1000: w_alu = $unsigned($signed(w_fwd_a) >>> w_opb[4:0]);
      4'b0110: w_alu = w_fwd_a - w_opb;
      4'b0111: w_alu = {31'd0, $signed(w_fwd_a) < $signed(w_opb)};
      4'b1001: w_alu = {31'd0, w_fwd_a < w_opb};
      default: w_alu = 32'd0;
    endcase
  end

  assign flush_o         = branch_i & (w_fwd_a == w_fwd_b);
  assign branch_target_o = addr_i + imme_i[13:0];
  assign stall_o         = memread_i & (rd_i != 5'd0) &
                           ((rd_i == id_rs1_i) | (rd_i == id_rs2_i));

  // EX -> EX/MEM boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu      <= 32'd0;
      r_wdata    <= 32'd0;
      r_rd       <= 5'd0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
    end else begin
      r_alu      <= w_alu;
      r_wdata    <= w_fwd_b;
      r_rd       <= rd_i;
      r_regwrite <= regwrite_i;
      r_memread  <= memread_i;
      r_memwrite <= memwrite_i;
      r_memtoreg <= memtoreg_i;
    end
  end

  assign exmem_alu_o      = r_alu;
  assign exmem_wdata_o    = r_wdata;
  assign exmem_rd_o       = r_rd;
  assign exmem_regwrite_o = r_regwrite;
  assign exmem_memread_o  = r_memread;
  assign exmem_memwrite_o = r_memwrite;
  assign exmem_memtoreg_o = r_memtoreg;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipeline and the consumer of the ID/EX pipeline register bundle. Forwards operands from EX/MEM and MEM/WB, executes the ALU operation, resolves branches, and detects load-use hazards. Registers results into the EX/MEM pipeline register consumed by the memory stage.

## Interface
Parameters: none; all widths are fixed.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- regwrite_i, alusrc_i, branch_i, memread_i, memwrite_i, memtoreg_i  in  1 each  ID/EX control bits
- imme_i  in  32  sign-extended immediate
- rdata1_i, rdata2_i  in  32  register-file read data
- addr_i  in  14  PC of the instruction in EX
- rd_i, rs1_i, rs2_i  in  5 each  register indices of the instruction in EX
- alucontrol_i  in  4  ALU operation code
- id_rs1_i, id_rs2_i  in  5 each  source indices of the instruction currently in ID
- wb_regwrite_i  in  1  MEM/WB write enable
- wb_rd_i  in  5  MEM/WB destination
- wb_data_i  in  32  MEM/WB write-back data
- exmem_alu_o  out  32  registered ALU result
- exmem_wdata_o  out  32  registered forwarded rs2 value (store data)
- exmem_rd_o  out  5  registered destination
- exmem_regwrite_o, exmem_memread_o, exmem_memwrite_o, exmem_memtoreg_o  out  1 each  registered control bits
- branch_target_o  out  14  branch target, combinational
- flush_o  out  1  branch taken, combinational
- stall_o  out  1  load-use hazard, combinational

## Operation
- **Forwarding, operand A = rs1.** Source priority:
  1. EX/MEM, when exmem_regwrite_o=1, exmem_rd_o≠0, exmem_rd_o==rs1_i and exmem_memread_o=0.
  2. Otherwise MEM/WB, when wb_regwrite_i=1, wb_rd_i≠0 and wb_rd_i==rs1_i.
  3. Otherwise rdata1_i.
- **Forwarding, operand B.** The forwarded rs2 value (fwd_b) uses the same rule applied to rs2_i/rdata2_i.
  - B = imme_i when alusrc_i=1, else fwd_b.
  - exmem_wdata_o always captures fwd_b.
- **ALU codes:**
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR
  - 0100 SLL, shift by B[4:0]; 0101 SRL; 1000 SRA
  - 0110 SUB; 0111 SLT, signed, result 1/0; 1001 SLTU
  - Any other code gives result 0.
  - All arithmetic is modulo 2^32.
- **Branch.**
  - flush_o = branch_i & (fwd_A == fwd_b). Equality is tested on the forwarded values, independent of alusrc_i.
  - branch_target_o = addr_i + imme_i[13:0], truncated to 14 bits (wraps).
- **Load-use.** stall_o = memread_i & (rd_i≠0) & ((rd_i==id_rs1_i) | (rd_i==id_rs2_i)).
  - Upstream holds IF/ID and loads a bubble into ID/EX.
  - This block does not gate its own capture on stall_o.
- **EX/MEM capture.** Every rising edge with rst_n=1 loads the ALU result, fwd_b, rd_i and the four control bits (regwrite, memread, memwrite, memtoreg).
  - A taken branch is still captured; it carries regwrite=0 from decode.

## Timing
- **Reset.** rst_n=0 at a rising edge clears all exmem_* outputs to 0.
  - Combinational outputs still follow their inputs during reset.
  - Reset mid-stream drops the in-flight EX/MEM instruction.
  - EX/MEM forwarding is inactive the cycle after reset, because exmem_regwrite_o=0.
- **Latency.**
  - ALU result appears on exmem_alu_o one cycle after the instruction is in EX.
  - flush_o, branch_target_o and stall_o are valid in the same cycle, with no register.
- **Simultaneous EX/MEM and MEM/WB match on the same register:** EX/MEM wins (youngest value).
- **Destination x0:** never forwarded, never stalls.
- **Load in EX/MEM matching a source:** not forwarded from EX/MEM; falls to MEM/WB or the register file. The load-use stall guarantees correctness.

## Test plan
- **Reset.** Drive rst_n=0 for 2 cycles with random inputs -> all exmem_* = 0; release, then ADD 5+7 -> exmem_alu_o=12 one cycle later.
- **Back-to-back forwarding.** ADD x3=1+2, then SUB x4=x3−x1 with rdata1_i stale=0, x1=1 -> second result 2 via EX/MEM.
- **Priority.** EX/MEM writes x5=9 while MEM/WB writes x5=4, current reads x5 -> 9 used. Repeat with rd=0 on both -> rdata value used.
- **Load-use.** memread_i=1, rd_i=6, id_rs2_i=6 -> stall_o=1. Same with rd_i=0 -> stall_o=0.
- **Branch.** branch_i=1, operands 0x10/0x10, addr_i=0x3FFC, imme_i=8 -> flush_o=1, branch_target_o=0x0004 (wrap). Operands unequal -> flush_o=0.
- **ALU sweep.** SRA 0x80000000>>4 -> 0xF8000000; SLT −1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0; code 1111 -> 0.
